// File: rtl/ulpi_rx_framer_pkg.sv
// Shared definitions for the ULPI receive framer: record kinds, RXCMD fields,
// EOP status bit positions and FSM state type.
package ulpi_rx_framer_pkg;

    // Record kind codes, carried in OUT_DATA[31:30]
    localparam logic [1:0] KIND_DATA = 2'b00;
    localparam logic [1:0] KIND_SOP  = 2'b01;
    localparam logic [1:0] KIND_EOP  = 2'b10;
    localparam logic [1:0] KIND_EVT  = 2'b11;

    // RXCMD field positions
    localparam int unsigned RXCMD_LS_LSB  = 0;
    localparam int unsigned RXCMD_EVT_LSB = 4;

    // RxEvent codes that mean RxActive is asserted
    localparam logic [1:0] RXEVT_ACTIVE = 2'b01;
    localparam logic [1:0] RXEVT_ERROR  = 2'b11;

    // EOP status bit positions
    localparam int unsigned EOP_ERR_BIT   = 16;
    localparam int unsigned EOP_OVF_BIT   = 17;
    localparam int unsigned EOP_DIR_BIT   = 18;
    localparam int unsigned EOP_TRUNC_BIT = 19;

    typedef enum logic [1:0] {
        StIdle,
        StPkt,
        StSkip
    } state_e;

    // Assemble a full EOP record from the byte count and status flags
    function automatic logic [31:0] make_eop(input logic [15:0] count, input logic err,
                                             input logic ovf, input logic by_dir,
                                             input logic trunc);
        logic [31:0] rec;
        rec                = '0;
        rec[31:30]         = KIND_EOP;
        rec[15:0]          = count;
        rec[EOP_ERR_BIT]   = err;
        rec[EOP_OVF_BIT]   = ovf;
        rec[EOP_DIR_BIT]   = by_dir;
        rec[EOP_TRUNC_BIT] = trunc;
        return rec;
    endfunction

endpackage

// File: rtl/ulpi_rxcmd_decode.sv
// Combinational RXCMD field decode: RxActive, RxError and LineState.
module ulpi_rxcmd_decode
    import ulpi_rx_framer_pkg::*;
(
    input  logic [7:0] rxcmd,
    output logic       rx_active,
    output logic       rx_error,
    output logic [1:0] linestate
);

    logic [1:0] rx_event;

    // RxEvent 01/11 both mean the PHY is receiving; 11 additionally flags an error
    always_comb begin
        rx_event  = rxcmd[RXCMD_EVT_LSB +: 2];
        rx_active = (rx_event == RXEVT_ACTIVE) || (rx_event == RXEVT_ERROR);
        rx_error  = (rx_event == RXEVT_ERROR);
        linestate = rxcmd[RXCMD_LS_LSB +: 2];
    end

endmodule

// File: rtl/ulpi_rx_framer.sv
// ULPI receive framer: turns the demuxed capture stream into timestamped
// SOP/DATA/EOP/EVT records, one registered record per input cycle at most.
module ulpi_rx_framer
    import ulpi_rx_framer_pkg::*;
#(
    parameter int unsigned TS_W       = 30,
    parameter int unsigned MAX_LEN    = 1027,
    parameter int unsigned FILTER_DUP = 1
) (
    input  logic        ULPI_CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        IN_VALID,
    input  logic        IN_RXCMD,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_DIR,
    input  logic        OUT_FULL,
    output logic        OUT_WE,
    output logic [31:0] OUT_DATA,
    output logic [15:0] DROP_CNT,
    output logic        IN_PKT
);

    state_e          state_q, state_d;
    logic [TS_W-1:0] ts_q;
    logic [29:0]     ts_ext;
    logic [7:0]      last_q, last_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     drop_q, drop_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            trunc_q, trunc_d;
    logic            dir_q;
    logic            dir_fall;
    logic            is_cmd;
    logic            gen;
    logic            drop;
    logic [31:0]     rec;
    logic            we_q;
    logic [31:0]     data_q;

    logic            rx_active;
    logic            rx_error;
    logic [1:0]      linestate;

    ulpi_rxcmd_decode u_decode (
        .rxcmd     (IN_DATA),
        .rx_active (rx_active),
        .rx_error  (rx_error),
        .linestate (linestate)
    );

    // Input qualifiers and zero-extended timestamp for record bodies
    always_comb begin
        is_cmd   = IN_VALID && IN_RXCMD;
        dir_fall = dir_q && !IN_DIR;
        ts_ext   = 30'(ts_q);
    end

    // FSM next state, record generation and per-packet bookkeeping
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        gen     = 1'b0;
        rec     = '0;

        if (is_cmd) begin
            last_d = IN_DATA;
        end

        unique case (state_q)
            StIdle: begin
                if (is_cmd && rx_active) begin
                    if (!ENABLE) begin
                        state_d = StSkip;
                    end else begin
                        gen = 1'b1;
                        rec = {KIND_SOP, ts_ext};
                        // A lost SOP would leave an orphan packet, so skip it entirely
                        if (OUT_FULL) begin
                            state_d = StSkip;
                        end else begin
                            state_d = StPkt;
                            count_d = '0;
                            err_d   = rx_error;
                            ovf_d   = 1'b0;
                            trunc_d = 1'b0;
                        end
                    end
                end else if (is_cmd && ENABLE &&
                             ((IN_DATA != last_q) || (FILTER_DUP == 0))) begin
                    gen = 1'b1;
                    // LineState is re-inserted from the decoder; upper bits pass through
                    rec = {KIND_EVT, ts_ext[21:0], IN_DATA[7:2], linestate};
                end
            end
            StPkt: begin
                if (IN_VALID && !IN_RXCMD) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if ({16'd0, count_q} < MAX_LEN) begin
                        gen = 1'b1;
                        rec = {KIND_DATA, 22'd0, IN_DATA};
                    end else begin
                        trunc_d = 1'b1;
                    end
                end else if (is_cmd && rx_active) begin
                    if (rx_error) begin
                        err_d = 1'b1;
                    end
                end else if (is_cmd) begin
                    gen     = 1'b1;
                    rec     = make_eop(count_q, err_q, ovf_q, 1'b0, trunc_q);
                    state_d = StIdle;
                end else if (dir_fall) begin
                    gen     = 1'b1;
                    rec     = make_eop(count_q, err_q, ovf_q, 1'b1, trunc_q);
                    state_d = StIdle;
                end
            end
            StSkip: begin
                if ((is_cmd && !rx_active) || dir_fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        drop = gen && OUT_FULL;
        // Only a dropped in-packet record marks the packet; a dropped EOP is just counted
        if (drop && (state_q == StPkt) && (state_d == StPkt)) begin
            ovf_d = 1'b1;
        end

        drop_d = drop_q;
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // State, counters and output register
    always_ff @(posedge ULPI_CLK) begin
        if (RST) begin
            state_q <= StIdle;
            ts_q    <= '0;
            last_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
            dir_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 1'b1;
            last_q  <= last_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
            dir_q   <= IN_DIR;
            we_q    <= gen && !OUT_FULL;
            if (gen && !OUT_FULL) begin
                data_q <= rec;
            end
        end
    end

    // Output mapping
    always_comb begin
        OUT_WE   = we_q;
        OUT_DATA = data_q;
        DROP_CNT = drop_q;
        IN_PKT   = (state_q == StPkt);
    end

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Scoreboard bench for ulpi_rx_framer: stimulus pushes expected records with the
// cycle they must appear in; a monitor pops and compares on every OUT_WE.
module tb_ulpi_rx_framer;

    logic        ULPI_CLK;
    logic        RST;
    logic        ENABLE;
    logic        IN_VALID;
    logic        IN_RXCMD;
    logic [7:0]  IN_DATA;
    logic        IN_DIR;
    logic        OUT_FULL;
    logic        OUT_WE;
    logic [31:0] OUT_DATA;
    logic [15:0] DROP_CNT;
    logic        IN_PKT;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    ulpi_rx_framer #(
        .TS_W       (30),
        .MAX_LEN    (4),
        .FILTER_DUP (1)
    ) dut (
        .ULPI_CLK (ULPI_CLK),
        .RST      (RST),
        .ENABLE   (ENABLE),
        .IN_VALID (IN_VALID),
        .IN_RXCMD (IN_RXCMD),
        .IN_DATA  (IN_DATA),
        .IN_DIR   (IN_DIR),
        .OUT_FULL (OUT_FULL),
        .OUT_WE   (OUT_WE),
        .OUT_DATA (OUT_DATA),
        .DROP_CNT (DROP_CNT),
        .IN_PKT   (IN_PKT)
    );

    initial ULPI_CLK = 1'b0;
    always #5 ULPI_CLK = ~ULPI_CLK;

    // Cycle count since reset; equals the timestamp the design should report
    always @(posedge ULPI_CLK) cyc <= RST ? 0 : cyc + 1;

    function automatic logic [31:0] r_data(input logic [7:0] b);
        return {2'b00, 22'd0, b};
    endfunction

    function automatic logic [31:0] r_sop(input int ts);
        logic [29:0] t;
        t = 30'(ts);
        return {2'b01, t};
    endfunction

    function automatic logic [31:0] r_evt(input logic [7:0] cmd, input int ts);
        logic [29:0] t;
        t = 30'(ts);
        return {2'b11, t[21:0], cmd};
    endfunction

    function automatic logic [31:0] r_eop(input int cnt, input logic err, input logic ovf,
                                          input logic by_dir, input logic trunc);
        logic [15:0] c;
        c = 16'(cnt);
        return {2'b10, 10'd0, trunc, by_dir, ovf, err, c};
    endfunction

    // Expect a record one cycle after the stimulus about to be driven
    task automatic expect_rec(input logic [31:0] d);
        exp_q.push_back('{d, cyc + 1});
    endtask

    task automatic step(input logic v, input logic rx, input logic [7:0] d,
                        input logic dir, input logic full);
        IN_VALID = v;
        IN_RXCMD = rx;
        IN_DATA  = d;
        IN_DIR   = dir;
        OUT_FULL = full;
        @(posedge ULPI_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    initial begin
        RST = 1'b1;
        ENABLE = 1'b1;
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        check("reset out_we", {31'd0, OUT_WE}, 32'd0);
        check("reset out_data", OUT_DATA, 32'd0);
        check("reset drop_cnt", {16'd0, DROP_CNT}, 32'd0);
        check("reset in_pkt", {31'd0, IN_PKT}, 32'd0);
        RST = 1'b0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge ULPI_CLK);
                    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                        e = exp_q.pop_front();
                        n_tests++;
                        n_fail++;
                        $display("FAIL record missing: want %08h at cycle %0d",
                                 e.data, e.cyc);
                    end
                    if (OUT_WE) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL record unexpected: got %08h at cycle %0d, want none",
                                     OUT_DATA, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (OUT_DATA !== e.data || cyc != e.cyc) begin
                                n_fail++;
                                $display("FAIL record: got %08h at cycle %0d, want %08h at %0d",
                                         OUT_DATA, cyc, e.data, e.cyc);
                            end
                        end
                    end
                end
            end
        join_none

        step(0, 0, 8'h00, 0, 0);

        // Line-state event, then an identical RXCMD that must be filtered
        expect_rec(r_evt(8'h01, cyc));
        step(1, 1, 8'h01, 1, 0);
        step(1, 1, 8'h01, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // Normal packet ended by RXCMD, followed by a new line-state event
        expect_rec(r_sop(cyc));
        step(1, 1, 8'h11, 1, 0);
        check("in_pkt in packet", {31'd0, IN_PKT}, 32'd1);
        expect_rec(r_data(8'hA5));
        step(1, 0, 8'hA5, 1, 0);
        expect_rec(r_data(8'h5A));
        step(1, 0, 8'h5A, 1, 0);
        expect_rec(r_data(8'hC3));
        step(1, 0, 8'hC3, 1, 0);
        expect_rec(r_eop(3, 0, 0, 0, 0));
        step(1, 1, 8'h01, 1, 0);
        check("in_pkt after eop", {31'd0, IN_PKT}, 32'd0);
        expect_rec(r_evt(8'h00, cyc));
        step(1, 1, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // Packet ended by DIR falling
        expect_rec(r_sop(cyc));
        step(1, 1, 8'h11, 1, 0);
        expect_rec(r_data(8'h11));
        step(1, 0, 8'h11, 1, 0);
        expect_rec(r_data(8'h22));
        step(1, 0, 8'h22, 1, 0);
        expect_rec(r_eop(2, 0, 0, 1, 0));
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);

        // Over-length packet, with the next SOP in the very next cycle
        expect_rec(r_sop(cyc));
        step(1, 1, 8'h11, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) expect_rec(r_data(8'(i)));
            step(1, 0, 8'(i), 1, 0);
        end
        expect_rec(r_eop(6, 0, 0, 0, 1));
        step(1, 1, 8'h01, 1, 0);

        // Back-to-back SOP; middle byte lost to a full FIFO
        expect_rec(r_sop(cyc));
        step(1, 1, 8'h11, 1, 0);
        expect_rec(r_data(8'hB1));
        step(1, 0, 8'hB1, 1, 0);
        step(1, 0, 8'hB2, 1, 1);
        expect_rec(r_data(8'hB3));
        step(1, 0, 8'hB3, 1, 0);
        expect_rec(r_eop(3, 0, 1, 0, 0));
        step(1, 1, 8'h01, 1, 0);
        check("drop_cnt after data loss", {16'd0, DROP_CNT}, 32'd1);

        // SOP lost to a full FIFO: whole packet skipped silently
        step(1, 1, 8'h11, 1, 1);
        check("in_pkt while skipping", {31'd0, IN_PKT}, 32'd0);
        step(1, 0, 8'h10, 1, 0);
        step(1, 0, 8'h20, 1, 0);
        step(1, 1, 8'h00, 1, 0);
        check("drop_cnt after sop loss", {16'd0, DROP_CNT}, 32'd2);
        expect_rec(r_evt(8'h02, cyc));
        step(1, 1, 8'h02, 1, 0);

        // RxError seen mid-packet is latched into the EOP
        expect_rec(r_sop(cyc));
        step(1, 1, 8'h11, 1, 0);
        expect_rec(r_data(8'h41));
        step(1, 0, 8'h41, 1, 0);
        step(1, 1, 8'h31, 1, 0);
        expect_rec(r_data(8'h42));
        step(1, 0, 8'h42, 1, 0);
        expect_rec(r_eop(2, 1, 0, 0, 0));
        step(1, 1, 8'h01, 1, 0);

        // Capture disabled: no events, packet skipped
        ENABLE = 1'b0;
        step(1, 1, 8'h03, 1, 0);
        step(1, 1, 8'h11, 1, 0);
        check("in_pkt when disabled", {31'd0, IN_PKT}, 32'd0);
        step(1, 0, 8'h77, 1, 0);
        step(1, 1, 8'h01, 1, 0);
        ENABLE = 1'b1;
        step(1, 1, 8'h01, 1, 0);
        expect_rec(r_evt(8'h03, cyc));
        step(1, 1, 8'h03, 1, 0);
        check("drop_cnt unchanged", {16'd0, DROP_CNT}, 32'd2);

        // Reset in the middle of a packet
        expect_rec(r_sop(cyc));
        step(1, 1, 8'h11, 1, 0);
        expect_rec(r_data(8'h99));
        step(1, 0, 8'h99, 1, 0);
        RST = 1'b1;
        step(1, 0, 8'h55, 1, 0);
        check("out_we after mid reset", {31'd0, OUT_WE}, 32'd0);
        check("in_pkt after mid reset", {31'd0, IN_PKT}, 32'd0);
        check("drop_cnt after mid reset", {16'd0, DROP_CNT}, 32'd0);
        RST = 1'b0;
        expect_rec(r_sop(0));
        step(1, 1, 8'h11, 1, 0);
        expect_rec(r_data(8'h66));
        step(1, 0, 8'h66, 1, 0);
        expect_rec(r_eop(1, 0, 0, 0, 0));
        step(1, 1, 8'h01, 1, 0);

        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
